// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid slot. All outputs are registered.
// Optional statistics counters are enabled by defining PIPE_REG_STATS_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | no valid entry, out_data_o = BUBBLE_DATA
//   ST_ONE   | main register holds the head entry
//   ST_FULL  | main holds the head, skid holds the next entry
module pipe_skid_reg #(
  parameter int                DATA_W      = 211,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
`ifdef PIPE_REG_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        count_q, count_d;
  logic              accept, consume;

  assign accept  = in_valid_i & in_ready_q;
  assign consume = out_valid_q & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE_DATA;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_d = in_data_i;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data_i;
        end else if (consume) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_DATA;
        end
      end
      ST_FULL: begin
        if (consume) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE_DATA;
      end
    endcase
    // Flush wins over any handshake, including one that completed this cycle.
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_DATA;
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    count_d     = state_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign count_o     = count_q;

`ifdef PIPE_REG_STATS_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid_q && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!out_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg with a queue-based reference model.
// Statistics checks are included when PIPE_REG_STATS_EN is defined.
module tb_pipe_skid_reg;
  localparam int          W   = 211;
  localparam logic [W-1:0] BUB = 211'h5A5A_0F0F;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] in_data_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [W-1:0] out_data_o;
  logic [1:0]   count_o;
`ifdef PIPE_REG_STATS_EN
  logic [31:0]  stall_cnt_o, bubble_cnt_o;
  int unsigned  m_stall, m_bubble;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  pipe_skid_reg #(.DATA_W(W), .BUBBLE_DATA(BUB)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .count_o     (count_o)
`ifdef PIPE_REG_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : BUB;
  endfunction

  // Drive one cycle and advance the reference model across the edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r,
                       input logic f, input logic rs);
    bit acc, con;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    rst_i       = rs;
    acc = v && (exp_q.size() < 2);
    con = (exp_q.size() > 0) && r;
`ifdef PIPE_REG_STATS_EN
    if (rs) begin
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (exp_q.size() > 0 && !r) m_stall++;
      if (exp_q.size() == 0) m_bubble++;
    end
`endif
    @(posedge clk_i);
    #1;
    if (rs || f) exp_q.delete();
    else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, W'(7), 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    checks++; if (out_data_o !== BUB) begin errors++; $display("FAIL reset_out_data got=%h exp=%h", out_data_o, BUB); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      checks++; if (out_data_o !== W'(i)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data_o, W'(i)); end
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid_o); end
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready_o); end
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== BUB) begin errors++; $display("FAIL stream_drain got=%b/%h exp=0/%h", out_valid_o, out_data_o, BUB); end
  endtask

  task automatic test_stall();
    drive(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 2'd1 || out_data_o !== W'(10)) begin errors++; $display("FAIL stall_one got=%0d/%h exp=1/a", count_o, out_data_o); end
    drive(1'b1, W'(11), 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL stall_count got=%0d exp=2", count_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready_o); end
    checks++; if (out_data_o !== W'(10)) begin errors++; $display("FAIL stall_head got=%h exp=a", out_data_o); end
    drive(1'b1, W'(12), 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 2'd2 || out_data_o !== W'(10)) begin errors++; $display("FAIL stall_hold got=%0d/%h exp=2/a", count_o, out_data_o); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_data_o !== W'(11) || count_o !== 2'd1) begin errors++; $display("FAIL stall_release1 got=%h/%0d exp=b/1", out_data_o, count_o); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== BUB) begin errors++; $display("FAIL stall_release2 got=%b/%h exp=0/%h", out_valid_o, out_data_o, BUB); end
  endtask

  task automatic test_flush_full();
    drive(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
    drive(1'b1, W'(11), 1'b0, 1'b0, 1'b0);
    drive(1'b1, W'(12), 1'b0, 1'b1, 1'b0);
    checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    checks++; if (out_data_o !== BUB || out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_out got=%b/%h exp=0/%h", out_valid_o, out_data_o, BUB); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready_o); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (out_data_o === W'(12) || out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_c[%0d] got=%b/%h exp=0/%h", i, out_valid_o, out_data_o, BUB); end
    end
    // Consume in the flush cycle: the entry is delivered and not re-presented.
    drive(1'b1, W'(20), 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== BUB) begin errors++; $display("FAIL flush_consume got=%b/%h exp=0/%h", out_valid_o, out_data_o, BUB); end
  endtask

  task automatic test_rst_flush();
    drive(1'b1, W'(5), 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL rstflush_pre got=%0d exp=1", count_o); end
    drive(1'b1, W'(6), 1'b0, 1'b1, 1'b1);
    checks++; if (count_o !== 2'd0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL rstflush_state got=%0d/%b exp=0/1", count_o, in_ready_o); end
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== BUB) begin errors++; $display("FAIL rstflush_out got=%b/%h exp=0/%h", out_valid_o, out_data_o, BUB); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rstflush_late got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_random();
    int unsigned next_val = 100;
    int unsigned sent = 0, rcvd = 0;
    logic [W-1:0] d;
    logic v, r;
    for (int c = 0; c < 10000; c++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = W'(next_val) | (W'(next_val) << 150);
      if (out_valid_o && r) begin
        rcvd++;
        checks++; if (out_data_o !== exp_head()) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", c, out_data_o, exp_head()); end
      end
      if (v && exp_q.size() < 2) begin sent++; next_val++; end
      drive(v, d, r, 1'b0, 1'b0);
      checks++; if (count_o !== 2'(exp_q.size()) || in_ready_o !== (exp_q.size() < 2) || out_valid_o !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rand_ctrl[%0d] got=%0d/%b/%b exp=%0d", c, count_o, in_ready_o, out_valid_o, exp_q.size());
      end
      checks++; if (out_data_o !== exp_head()) begin errors++; $display("FAIL rand_head[%0d] got=%h exp=%h", c, out_data_o, exp_head()); end
    end
    for (int c = 0; c < 4; c++) begin
      if (out_valid_o) begin
        rcvd++;
        checks++; if (out_data_o !== exp_head()) begin errors++; $display("FAIL rand_drain[%0d] got=%h exp=%h", c, out_data_o, exp_head()); end
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (rcvd != sent) begin errors++; $display("FAIL rand_total got=%0d exp=%0d", rcvd, sent); end
  endtask

`ifdef PIPE_REG_STATS_EN
  task automatic test_stats();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (stall_cnt_o !== 32'd0 || bubble_cnt_o !== 32'd0) begin errors++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", stall_cnt_o, bubble_cnt_o); end
    drive(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (stall_cnt_o !== 32'd5) begin errors++; $display("FAIL stats_stall got=%0d exp=5", stall_cnt_o); end
    checks++; if (bubble_cnt_o !== 32'd4) begin errors++; $display("FAIL stats_bubble got=%0d exp=4", bubble_cnt_o); end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checks++; if (stall_cnt_o !== 32'(m_stall) || bubble_cnt_o !== 32'(m_bubble)) begin errors++; $display("FAIL stats_flush got=%0d/%0d exp=%0d/%0d", stall_cnt_o, bubble_cnt_o, m_stall, m_bubble); end
  endtask
`endif

  initial begin
`ifdef PIPE_REG_STATS_EN
    m_stall  = 0;
    m_bubble = 0;
`endif
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_rst_flush();
    test_random();
`ifdef PIPE_REG_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
